// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, HD44780 opcodes and helpers for the LCD bus scheduler
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    SETUP,
    ENHI,
    HOLD,
    WAIT
  } lcd_state_t;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;

  localparam int INIT_LEN = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) are the slow HD44780 instructions
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// rtl/lcd_init_rom.sv - HD44780 8-bit init command table
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [1:0] idx,
  output logic [7:0] init_byte
);

  always_comb begin
    init_byte = FUNC_SET_8B2L;
    case (idx)
      2'd0: init_byte = FUNC_SET_8B2L;
      2'd1: init_byte = DISP_ON;
      2'd2: init_byte = CLEAR;
      2'd3: init_byte = ENTRY_INC;
      default: init_byte = FUNC_SET_8B2L;
    endcase
  end

endmodule

// File: rtl/lcd_bus_sched.sv
// rtl/lcd_bus_sched.sv - two-requester HD44780 write scheduler with power-up init sequence
module lcd_bus_sched
  import lcd_pkg::*;
#(
  parameter int EN_SETUP   = 4,
  parameter int EN_HIGH    = 12,
  parameter int EN_HOLD    = 4,
  parameter int WAIT_SHORT = 2000,
  parameter int WAIT_LONG  = 82000,
  parameter int POWERUP    = 750000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iREQ0,
  input  logic       iRS0,
  input  logic [7:0] iDATA0,
  output logic       oGNT0,
  input  logic       iREQ1,
  input  logic       iRS1,
  input  logic [7:0] iDATA1,
  output logic       oGNT1,
  output logic       oBUSY,
  output logic       oINIT_DONE,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam int MAX_CNT = max2(max2(max2(EN_SETUP, EN_HIGH), max2(EN_HOLD, WAIT_SHORT)),
                                max2(WAIT_LONG, POWERUP));
  localparam int CW = $clog2(MAX_CNT + 1);

  lcd_state_t     state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [1:0]     idx, idx_n;
  logic           prio, prio_n;
  logic           rs_q, rs_n;
  logic [7:0]     data_q, data_n;
  logic           gnt0_q, gnt0_n, gnt1_q, gnt1_n;
  logic           done_q, done_n;
  logic [7:0]     rom_byte;
  logic           cnt_last;
  logic           pick;

  lcd_init_rom u_rom (
    .idx       (idx),
    .init_byte (rom_byte)
  );

  // Each timed state is loaded with its length N on entry and leaves when the count reaches 1
  assign cnt_last = (cnt <= CW'(1));
  assign pick     = (iREQ0 && iREQ1) ? prio : iREQ1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= PWRUP;
      cnt    <= CW'(POWERUP);
      idx    <= 2'd0;
      prio   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      prio   <= prio_n;
      rs_q   <= rs_n;
      data_q <= data_n;
      gnt0_q <= gnt0_n;
      gnt1_q <= gnt1_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_last ? cnt : (cnt - CW'(1));
    idx_n   = idx;
    prio_n  = prio;
    rs_n    = rs_q;
    data_n  = data_q;
    gnt0_n  = 1'b0;
    gnt1_n  = 1'b0;
    done_n  = done_q;
    case (state)
      PWRUP: begin
        if (cnt_last) begin
          state_n = INIT;
          idx_n   = 2'd0;
        end
      end
      INIT: begin
        rs_n    = 1'b0;
        data_n  = rom_byte;
        state_n = SETUP;
        cnt_n   = CW'(EN_SETUP);
      end
      IDLE: begin
        if (iREQ0 || iREQ1) begin
          rs_n    = pick ? iRS1 : iRS0;
          data_n  = pick ? iDATA1 : iDATA0;
          gnt0_n  = !pick;
          gnt1_n  = pick;
          prio_n  = !pick;
          state_n = SETUP;
          cnt_n   = CW'(EN_SETUP);
        end
      end
      SETUP: begin
        if (cnt_last) begin
          state_n = ENHI;
          cnt_n   = CW'(EN_HIGH);
        end
      end
      ENHI: begin
        if (cnt_last) begin
          state_n = HOLD;
          cnt_n   = CW'(EN_HOLD);
        end
      end
      HOLD: begin
        if (cnt_last) begin
          state_n = WAIT;
          cnt_n   = is_long_cmd(rs_q, data_q) ? CW'(WAIT_LONG) : CW'(WAIT_SHORT);
        end
      end
      WAIT: begin
        if (cnt_last) begin
          if (done_q) begin
            state_n = IDLE;
          end else if (idx == 2'(INIT_LEN - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = INIT;
          end
        end
      end
      default: state_n = PWRUP;
    endcase
  end

  assign oGNT0      = gnt0_q;
  assign oGNT1      = gnt1_q;
  assign oBUSY      = (state != IDLE);
  assign oINIT_DONE = done_q;
  assign LCD_DATA   = data_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = (state == ENHI);

endmodule

// File: tb/tb_lcd_bus_sched.sv
// tb/tb_lcd_bus_sched.sv - directed self-checking bench for lcd_bus_sched
module tb_lcd_bus_sched;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iREQ0, iRS0, iREQ1, iRS1;
  logic [7:0] iDATA0, iDATA1;
  logic       oGNT0, oGNT1, oBUSY, oINIT_DONE;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN;

  int cyc = 0;
  int total = 0;
  int fails = 0;
  int g0 = 0;
  int g1 = 0;
  int b0, b1;

  lcd_bus_sched #(
    .EN_SETUP(2), .EN_HIGH(3), .EN_HOLD(2),
    .WAIT_SHORT(20), .WAIT_LONG(50), .POWERUP(100)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iREQ0(iREQ0), .iRS0(iRS0), .iDATA0(iDATA0), .oGNT0(oGNT0),
    .iREQ1(iREQ1), .iRS1(iRS1), .iDATA1(iDATA1), .oGNT1(oGNT1),
    .oBUSY(oBUSY), .oINIT_DONE(oINIT_DONE),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oGNT0 === 1'b1) g0 = g0 + 1;
    if (oGNT1 === 1'b1) g1 = g1 + 1;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp)
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    tick();
    cyc = 0;
    chk("rst_en", LCD_EN, 0);
    chk("rst_rs", LCD_RS, 0);
    chk("rst_data", LCD_DATA, 8'h00);
    chk("rst_rw", LCD_RW, 0);
    chk("rst_busy", oBUSY, 1);
    chk("rst_done", oINIT_DONE, 0);
    chk("rst_gnt", {oGNT1, oGNT0}, 0);
    iRST = 1'b0;
  endtask

  task automatic init_seq(input string p);
    goto(102);  chk({p, "_en_pre"}, LCD_EN, 0);
    goto(103);  chk({p, "_en_rise0"}, LCD_EN, 1);
                chk({p, "_d0"}, LCD_DATA, 8'h38);
                chk({p, "_rs0"}, LCD_RS, 0);
    goto(106);  chk({p, "_en_fall0"}, LCD_EN, 0);
                chk({p, "_d0_hold"}, LCD_DATA, 8'h38);
    goto(131);  chk({p, "_d1"}, {LCD_EN, LCD_DATA}, {1'b1, 8'h0C});
    goto(159);  chk({p, "_d2"}, {LCD_EN, LCD_DATA}, {1'b1, 8'h01});
    goto(216);  chk({p, "_long_gap"}, LCD_EN, 0);
    goto(217);  chk({p, "_d3"}, {LCD_EN, LCD_DATA}, {1'b1, 8'h06});
    goto(241);  chk({p, "_done_pre"}, oINIT_DONE, 0);
                chk({p, "_no_gnt"}, (g0 - b0) + (g1 - b1), 0);
  endtask

  initial begin
    iRST = 1'b1;
    iREQ0 = 1'b0; iRS0 = 1'b0; iDATA0 = 8'h00;
    iREQ1 = 1'b0; iRS1 = 1'b0; iDATA1 = 8'h00;
    tick();

    // Reset then idle through the full init sequence
    do_reset();
    b0 = g0; b1 = g1;
    init_seq("init");
    goto(242);  chk("init_done", oINIT_DONE, 1);
                chk("init_idle", oBUSY, 0);

    // Single write from requester 1
    iREQ1 = 1'b1; iRS1 = 1'b1; iDATA1 = 8'h41;
    goto(243);  chk("w1_gnt", {oGNT1, oGNT0}, 2'b10);
                chk("w1_busy", oBUSY, 1);
    iREQ1 = 1'b0;
    goto(244);  chk("w1_gnt_pulse", {oGNT1, oGNT0}, 2'b00);
                chk("w1_setup", LCD_EN, 0);
    goto(245);  chk("w1_en", {LCD_EN, LCD_RS, LCD_DATA}, {1'b1, 1'b1, 8'h41});
    goto(247);  chk("w1_en_last", LCD_EN, 1);
    goto(248);  chk("w1_hold0", {LCD_EN, LCD_RS, LCD_DATA}, {1'b0, 1'b1, 8'h41});
    goto(249);  chk("w1_hold1", {LCD_RS, LCD_DATA}, {1'b1, 8'h41});
    goto(269);  chk("w1_busy_end", oBUSY, 1);
    goto(270);  chk("w1_idle", oBUSY, 0);
                chk("w1_rw", LCD_RW, 0);

    // Contention: both requesters held continuously
    iREQ0 = 1'b1; iRS0 = 1'b1; iDATA0 = 8'hA0;
    iREQ1 = 1'b1; iRS1 = 1'b1; iDATA1 = 8'hB1;
    goto(271);  chk("rr_g0a", {oGNT1, oGNT0, LCD_DATA}, {2'b01, 8'hA0});
    goto(299);  chk("rr_g1a", {oGNT1, oGNT0, LCD_DATA}, {2'b10, 8'hB1});
    goto(327);  chk("rr_g0b", {oGNT1, oGNT0, LCD_DATA}, {2'b01, 8'hA0});
    goto(355);  chk("rr_g1b", {oGNT1, oGNT0, LCD_DATA}, {2'b10, 8'hB1});
    iREQ0 = 1'b0; iREQ1 = 1'b0;
    goto(382);  chk("rr_idle", oBUSY, 0);

    // Long wait for return-home, short wait for the same byte as data
    iREQ0 = 1'b1; iRS0 = 1'b0; iDATA0 = 8'h02;
    goto(383);  chk("lw_gnt", oGNT0, 1);
    iREQ0 = 1'b0;
    goto(439);  chk("lw_busy", oBUSY, 1);
    goto(440);  chk("lw_idle", oBUSY, 0);
    iREQ0 = 1'b1; iRS0 = 1'b1; iDATA0 = 8'h02;
    goto(441);  chk("sw_gnt", {oGNT0, LCD_RS}, 2'b11);
    iREQ0 = 1'b0;
    goto(467);  chk("sw_busy", oBUSY, 1);
    goto(468);  chk("sw_idle", oBUSY, 0);

    // Reset in the middle of ENHI, with requester 0 held through the re-init
    iREQ1 = 1'b1; iRS1 = 1'b1; iDATA1 = 8'h55;
    goto(469);  chk("rh_gnt", oGNT1, 1);
    iREQ1 = 1'b0;
    goto(472);  chk("rh_en", LCD_EN, 1);
    iREQ0 = 1'b1; iRS0 = 1'b1; iDATA0 = 8'h5A;
    do_reset();
    b0 = g0; b1 = g1;
    init_seq("reinit");
    goto(242);  chk("reinit_done", oINIT_DONE, 1);
                chk("reinit_gnt_pre", oGNT0, 0);
    goto(243);  chk("reinit_gnt", {oGNT1, oGNT0, LCD_DATA}, {2'b01, 8'h5A});
    iREQ0 = 1'b0;
    goto(300);  chk("done_sticky", oINIT_DONE, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/lcd_bus_sched.md
LCD_BUS_SCHED -- requirements
Module: lcd_bus_sched

Interface
REQ-001 Parameters, given as name, default and meaning:
- EN_SETUP, 4: cycles from RS/DATA valid to LCD_EN rise.
- EN_HIGH, 12: cycles LCD_EN is held high.
- EN_HOLD, 4: cycles RS/DATA are held after LCD_EN falls.
- WAIT_SHORT, 2000: post-write wait for ordinary commands and data.
- WAIT_LONG, 82000: post-write wait for clear/home.
- POWERUP, 750000: cycles of delay after reset before the init sequence.
REQ-002 Ports, given as name, direction, width and meaning:
- iCLK, in, 1: single clock.
- iRST, in, 1: reset, synchronous, active-high.
- iREQ0, in, 1: requester 0 transaction request.
- iRS0, in, 1: requester 0 register select.
- iDATA0, in, 8: requester 0 byte.
- oGNT0, out, 1: requester 0 accept pulse.
- iREQ1, in, 1: requester 1 transaction request.
- iRS1, in, 1: requester 1 register select.
- iDATA1, in, 8: requester 1 byte.
- oGNT1, out, 1: requester 1 accept pulse.
- oBUSY, out, 1: high whenever the state is not IDLE.
- oINIT_DONE, out, 1: init sequence complete.
- LCD_DATA, out, 8: HD44780 data bus.
- LCD_RS, out, 1: HD44780 register select.
- LCD_RW, out, 1: HD44780 read/write, always 0.
- LCD_EN, out, 1: HD44780 enable strobe.

Function
REQ-003 The scheduler SHALL implement states PWRUP, INIT, IDLE, SETUP, ENHI, HOLD and WAIT, with one shared down-counter sized to hold the largest parameter.
REQ-004 PWRUP SHALL count POWERUP cycles, then enter INIT with init index 0.
REQ-005 INIT SHALL load the init entry at the current index (RS=0, bytes 0x38, 0x0C, 0x01, 0x06) and enter SETUP; no oGNT is issued.
REQ-006 In IDLE, at a clock edge where any iREQx is sampled high, the scheduler SHALL:
- pick one requester by round-robin (on a tie, the requester not granted last wins; the pointer favours requester 0 after reset);
- register that requester's iRS/iDATA onto LCD_RS/LCD_DATA;
- pulse the matching oGNTx high for exactly one cycle, coincident with entering SETUP.
REQ-007 The bus-cycle timing SHALL be:
- SETUP lasts EN_SETUP cycles with LCD_EN=0.
- ENHI lasts EN_HIGH cycles with LCD_EN=1.
- HOLD lasts EN_HOLD cycles with LCD_EN=0, LCD_DATA and LCD_RS unchanged.
- WAIT lasts WAIT_LONG cycles when RS=0 and the byte is in {0x01,0x02,0x03}, otherwise WAIT_SHORT cycles.
REQ-008 On WAIT expiry:
- during the init sequence, the index SHALL increment and the state return to INIT, or after index 3 the state SHALL go to IDLE with oINIT_DONE set;
- otherwise the state SHALL go to IDLE.
REQ-009 Requesters SHALL hold iREQx, iRSx and iDATAx stable until they see oGNTx; the scheduler SHALL ignore request inputs in every state except IDLE.
REQ-010 Latency from a request sampled in IDLE to the LCD_EN rise SHALL be exactly 1+EN_SETUP cycles.
REQ-011 Bus-cycle to next-grant spacing SHALL be at least EN_SETUP+EN_HIGH+EN_HOLD+WAIT+1 cycles.
REQ-012 Outside a bus cycle, LCD_DATA and LCD_RS SHALL hold their last value; LCD_RW SHALL be constant 0.
REQ-013 oINIT_DONE SHALL stay high until reset.

Reset
REQ-014 While iRST is high at a clock edge, the following SHALL be set:
- state=PWRUP, counter loaded with POWERUP, init index 0, round-robin pointer to requester 0;
- LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, LCD_RW=0;
- oGNT0=oGNT1=0, oINIT_DONE=0, oBUSY=1.
REQ-015 A reset asserted mid-operation (including during ENHI) SHALL drop LCD_EN at that same edge, abandon the transaction without a grant, and rerun the full power-up and init sequence.

Structure
REQ-016 A shared package lcd_pkg SHALL hold:
- the state enumeration;
- HD44780 opcode constants (FUNC_SET_8B2L=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY_INC=0x06);
- the init table length (4).
REQ-017 The init table SHALL be the combinational sub-module lcd_init_rom (2-bit index in, 8-bit byte out); all timing SHALL stay in lcd_bus_sched.

Verification (sim parameters: POWERUP=100, WAIT_SHORT=20, WAIT_LONG=50, EN_SETUP=2, EN_HIGH=3, EN_HOLD=2)
REQ-018 The bench SHALL cover these scenarios:
- Reset then idle: first LCD_EN rise at cycle 100+3 with DATA=0x38; four EN pulses carry 0x38, 0x0C, 0x01, 0x06; the gap after 0x01 is 50 wait cycles; oINIT_DONE rises after the last wait; no oGNT pulse at any point.
- Single write after init: iREQ1=1, RS=1, DATA=0x41 → oGNT1 pulses one cycle; LCD_EN is high 3 cycles starting 3 cycles after the sample; DATA=0x41 and RS=1 are held through HOLD; oBUSY returns low 27 cycles after grant.
- Contention: iREQ0 and iREQ1 held continuously → grants alternate 0,1,0,1 starting with 0.
- Long wait: requester 0 writes RS=0, 0x02 → 50-cycle wait; a following RS=1, 0x02 write → 20-cycle wait.
- Reset during ENHI: LCD_EN falls the same edge; no grant occurs; the power-up delay of 100 cycles repeats; oINIT_DONE is 0 until the init sequence completes.
- Request during init: iREQ0 held from reset → no oGNT0 before oINIT_DONE; oGNT0 pulses in the first IDLE cycle.
